// File: rtl/outport_rx.sv
// Serial-to-byte receiver for one crossbar output port, feeding a tagged show-ahead FIFO.
// Define OUTPORT_RX_STATS_EN to build the pkt_cnt/drop_cnt statistics counters.
module outport_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        dout,
  input  logic                        valido_n,
  input  logic                        frameo_n,
  output logic [7:0]                  rx_data,
  output logic                        rx_sop,
  output logic                        rx_eop,
  output logic                        rx_err,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            pkt_cnt,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_RECV = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shreg;
  logic          r_pushed;
  logic          r_abort_pend;
  logic          r_abort_sop;

  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [10:0]   r_head;
  logic          r_valid;

  logic          w_sample;
  logic [7:0]    w_byte;
  logic          w_pop;
  logic          w_room;
  logic          w_byte_ok;
  logic          w_mark_push;
  logic          w_byte_push;
  logic          w_push;
  logic [10:0]   w_entry;
  logic          w_shift;
  logic          w_clr;
  logic          w_byte_done;
  logic          w_abort;
  logic [AW:0]   w_after_pop;
  logic [AW:0]   w_count_next;
  logic [AW-1:0] w_rd_next;
  logic [10:0]   w_head_next;

  assign w_sample    = ~valido_n;
  assign w_byte      = {dout, r_shreg[7:1]};
  assign w_pop       = r_valid & rx_ready;
  assign w_room      = (r_count != DEPTH_L) | w_pop;
  // A pending abort marker owns the next free slot, so it blocks byte pushes.
  assign w_mark_push = r_abort_pend & w_room;
  assign w_byte_ok   = ~r_abort_pend & w_room;
  assign w_byte_push = w_byte_done & w_byte_ok;
  assign w_push      = w_mark_push | w_byte_push;
  assign w_entry     = w_mark_push ? {1'b1, r_abort_sop, 1'b1, 8'h00}
                                   : {1'b0, ~r_pushed, frameo_n, w_byte};

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and datapath controls
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_clr        = 1'b0;
    w_byte_done  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (frameo_n) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_SYNC;
        end
      end
      ST_IDLE: begin
        if (!frameo_n) begin
          w_state_next = ST_RECV;
          w_shift      = w_sample;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (w_sample && (r_bitcnt == 3'd7)) begin
          w_byte_done = 1'b1;
          if (w_byte_ok) begin
            if (frameo_n) begin
              w_state_next = ST_IDLE;
              w_clr        = 1'b1;
            end else begin
              w_shift = 1'b1;
            end
          end else begin
            if (frameo_n) begin
              w_abort      = 1'b1;
              w_state_next = ST_IDLE;
              w_clr        = 1'b1;
            end else begin
              w_state_next = ST_DROP;
            end
          end
        end else if (frameo_n) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
          w_clr        = 1'b1;
        end else begin
          w_shift = w_sample;
        end
      end
      ST_DROP: begin
        if (frameo_n) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
          w_clr        = 1'b1;
        end else begin
          w_state_next = ST_DROP;
        end
      end
      default: begin
        w_state_next = ST_SYNC;
      end
    endcase
  end

  // Bit assembly and per-packet bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt <= 3'd0;
      r_shreg  <= 8'h00;
      r_pushed <= 1'b0;
    end else if (w_clr) begin
      r_bitcnt <= 3'd0;
      r_shreg  <= 8'h00;
      r_pushed <= 1'b0;
    end else begin
      if (w_shift) begin
        r_shreg  <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_byte_push) begin
        r_pushed <= 1'b1;
      end
    end
  end

  // Abort marker pending flag; a new abort wins over a marker leaving this cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_abort_pend <= 1'b0;
      r_abort_sop  <= 1'b0;
    end else if (w_abort) begin
      r_abort_pend <= 1'b1;
      r_abort_sop  <= ~r_pushed;
    end else if (w_mark_push) begin
      r_abort_pend <= 1'b0;
    end
  end

  // FIFO occupancy and next head entry
  always_comb begin
    if (w_pop) begin
      w_after_pop = r_count - (AW+1)'(1);
      w_rd_next   = r_rd_ptr + AW'(1);
    end else begin
      w_after_pop = r_count;
      w_rd_next   = r_rd_ptr;
    end
    if (w_push) begin
      w_count_next = w_after_pop + (AW+1)'(1);
    end else begin
      w_count_next = w_after_pop;
    end
    // An entry written into an otherwise-empty FIFO is forwarded straight to the head.
    if (w_count_next == (AW+1)'(0)) begin
      w_head_next = 11'h000;
    end else if (w_push && (w_after_pop == (AW+1)'(0))) begin
      w_head_next = w_entry;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // FIFO pointers, level and registered head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
      r_head   <= 11'h000;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
      r_valid  <= (w_count_next != (AW+1)'(0));
    end
  end

  assign rx_valid   = r_valid;
  assign rx_err     = r_head[10];
  assign rx_sop     = r_head[9];
  assign rx_eop     = r_head[8];
  assign rx_data    = r_head[7:0];
  assign fifo_level = r_count;

`ifdef OUTPORT_RX_STATS_EN
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_pkt_inc;

  assign w_pkt_inc = w_byte_push & frameo_n;

  // Wrapping packet statistics
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt  <= {CNT_W{1'b0}};
      r_drop_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
      if (w_abort) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  assign pkt_cnt  = {CNT_W{1'b0}};
  assign drop_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_outport_rx.sv
// Bench for outport_rx: a hand-written vector table, directed corner sequences and
// random frames checked every cycle against a queue-based packet model.
module tb_outport_rx;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        dout = 1'b0;
  logic        valido_n = 1'b1;
  logic        frameo_n = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_sop, rx_eop, rx_err, rx_valid;
  logic [2:0]  fifo_level;
  logic [15:0] pkt_cnt, drop_cnt;

  outport_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .dout(dout), .valido_n(valido_n),
    .frameo_n(frameo_n), .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_level(fifo_level), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: frame-level flags, a bit index and a queue of entries.
  logic [10:0] q[$];
  bit          m_synced, m_active, m_dropping, m_any, m_pend, m_pend_sop;
  int          m_nbits;
  logic [7:0]  m_byte;
  logic [15:0] m_pkt, m_drp;
  int          g_rdy_mode;

  typedef struct packed {
    logic       d, vn, fn, rdy;
    logic       valid, err, sop, eop;
    logic [7:0] data;
    logic [2:0] level;
  } vec_t;

  function automatic logic [15:0] st(input logic [15:0] v);
`ifdef OUTPORT_RX_STATS_EN
    return v;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] got_vec();
    return {17'h0, rx_valid, rx_err, rx_sop, rx_eop, rx_data, fifo_level, pkt_cnt, drop_cnt};
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [10:0] h;
    h = (q.size() > 0) ? q[0] : 11'h000;
    return {17'h0, (q.size() > 0), h, 3'(q.size()), st(m_pkt), st(m_drp)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_synced = 0; m_active = 0; m_dropping = 0; m_any = 0;
    m_pend = 0; m_pend_sop = 0; m_nbits = 0; m_byte = 8'h00;
    m_pkt = 16'h0000; m_drp = 16'h0000;
  endtask

  task automatic do_abort();
    m_pend = 1; m_pend_sop = !m_any; m_drp = m_drp + 16'd1;
    m_active = 0; m_dropping = 0;
  endtask

  task automatic model_step(input logic d, input logic vn, input logic fn, input logic rdy);
    bit pop, room, old_pend;
    pop = (q.size() > 0) && rdy;
    room = (q.size() < DEPTH) || pop;
    old_pend = m_pend;
    if (pop) void'(q.pop_front());
    if (old_pend && room) begin
      q.push_back({1'b1, m_pend_sop, 1'b1, 8'h00});
      m_pend = 0;
    end
    if (!m_synced) begin
      if (fn) m_synced = 1;
    end else if (!m_active) begin
      if (!fn) begin
        m_active = 1; m_dropping = 0; m_any = 0; m_nbits = 0; m_byte = 8'h00;
        if (!vn) begin m_byte[0] = d; m_nbits = 1; end
      end
    end else if (m_dropping) begin
      if (fn) do_abort();
    end else if (!vn && m_nbits == 7) begin
      m_byte[7] = d;
      if (!old_pend && room) begin
        q.push_back({1'b0, !m_any, fn, m_byte});
        m_any = 1; m_nbits = 0; m_byte = 8'h00;
        if (fn) begin m_pkt = m_pkt + 16'd1; m_active = 0; end
      end else if (fn) begin
        do_abort();
      end else begin
        m_dropping = 1;
      end
    end else if (fn) begin
      do_abort();
    end else if (!vn) begin
      m_byte[m_nbits] = d;
      m_nbits++;
    end
  endtask

  task automatic cyc(input logic d, input logic vn, input logic fn, input logic rdy);
    dout = d; valido_n = vn; frameo_n = fn; rx_ready = rdy;
    model_step(d, vn, fn, rdy);
    @(posedge clock);
    #1;
    check("model", got_vec(), exp_vec());
  endtask

  function automatic logic pick_rdy();
    if (g_rdy_mode == 0) return 1'b0;
    else if (g_rdy_mode == 1) return 1'b1;
    else return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic send_bits(input logic [63:0] bits, input int n, input int bub, input bit end_bub);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (bub == 1 || (bub == 2 && $urandom_range(0, 3) == 0)))
        cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, pick_rdy());
      cyc(bits[i], 1'b0, (i == n - 1) && !end_bub, pick_rdy());
    end
    if (end_bub) cyc(1'b0, 1'b1, 1'b1, pick_rdy());
  endtask

  task automatic expect_head(input string name, input logic err, input logic sop,
                             input logic eop, input logic [7:0] data);
    check(name, {51'h0, rx_valid, rx_err, rx_sop, rx_eop, rx_data},
          {51'h0, 1'b1, err, sop, eop, data});
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, rdy);
  endtask

  initial begin
    vec_t       tbl[10];
    logic [7:0] a5;
    logic [7:0] b3c;
    a5 = 8'hA5;
    b3c = 8'h3C;
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{a5[i-1], 1'b0, (i == 8), 1'b0, (i == 8), 1'b0, (i == 8), (i == 8),
                 (i == 8) ? 8'hA5 : 8'h00, (i == 8) ? 3'd1 : 3'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};

    model_reset();
    g_rdy_mode = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", got_vec(), 64'h0);
    reset_n = 1'b1;

    // Single byte 0xA5 from the vector table
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].d, tbl[i].vn, tbl[i].fn, tbl[i].rdy);
      check($sformatf("single_row%0d", i),
            {50'h0, rx_valid, rx_err, rx_sop, rx_eop, rx_data, fifo_level},
            {50'h0, tbl[i].valid, tbl[i].err, tbl[i].sop, tbl[i].eop, tbl[i].data, tbl[i].level});
    end
    check("single_pkt_cnt", 64'(pkt_cnt), 64'(st(16'd1)));

    // Bubbles every other cycle, 3-byte packet
    send_bits(64'hFF8001, 24, 1, 0);
    expect_head("bubble_b0", 1'b0, 1'b1, 1'b0, 8'h01);
    expect_head("bubble_b1", 1'b0, 1'b0, 1'b0, 8'h80);
    expect_head("bubble_b2", 1'b0, 1'b0, 1'b1, 8'hFF);

    // Partial byte: 12-bit frame
    send_bits(64'hB5A, 12, 0, 0);
    expect_head("partial_byte", 1'b0, 1'b1, 1'b0, 8'h5A);
    expect_head("partial_marker", 1'b1, 1'b0, 1'b1, 8'h00);
    check("partial_drop_cnt", 64'(drop_cnt), 64'(st(16'd1)));
    idle(2, 1'b1);

    // Overflow with stalled consumer, 6-byte packet
    send_bits(64'h665544332211, 48, 0, 0);
    check("ovf_level", 64'(fifo_level), 64'd4);
    expect_head("ovf_b0", 1'b0, 1'b1, 1'b0, 8'h11);
    expect_head("ovf_b1", 1'b0, 1'b0, 1'b0, 8'h22);
    expect_head("ovf_b2", 1'b0, 1'b0, 1'b0, 8'h33);
    expect_head("ovf_b3", 1'b0, 1'b0, 1'b0, 8'h44);
    expect_head("ovf_marker", 1'b1, 1'b0, 1'b1, 8'h00);
    idle(2, 1'b1);

    // Full boundary: byte completes on a full FIFO in the same cycle as a pop
    g_rdy_mode = 0;
    send_bits(64'hD8C4B2A1, 32, 0, 0);
    for (int i = 0; i < 8; i++) cyc(b3c[i], 1'b0, (i == 7), (i == 7));
    check("full_level", 64'(fifo_level), 64'd4);
    check("full_drop_cnt", 64'(drop_cnt), 64'(st(16'd2)));
    check("full_pkt_cnt", 64'(pkt_cnt), 64'(st(16'd4)));
    expect_head("full_h0", 1'b0, 1'b0, 1'b0, 8'hB2);
    expect_head("full_h1", 1'b0, 1'b0, 1'b0, 8'hC4);
    expect_head("full_h2", 1'b0, 1'b0, 1'b1, 8'hD8);
    expect_head("full_h3", 1'b0, 1'b1, 1'b1, 8'h3C);

    // Reset in the middle of a packet with a non-empty FIFO
    send_bits(64'h5E, 8, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("reset_mid", got_vec(), 64'h0);
    model_reset();
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    send_bits(64'h3C, 8, 0, 0);
    check("reset_next_level", 64'(fifo_level), 64'd1);
    expect_head("reset_next", 1'b0, 1'b1, 1'b1, 8'h3C);

    // Random frames against the model
    for (int f = 0; f < 150; f++) begin
      int n;
      g_rdy_mode = ($urandom_range(0, 4) == 0) ? 0 : 2;
      n = ($urandom_range(0, 1) == 1) ? 8 * $urandom_range(1, 5) : $urandom_range(1, 40);
      send_bits({$urandom, $urandom}, n, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
      g_rdy_mode = 2;
      for (int g = 0; g < $urandom_range(0, 2); g++)
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, pick_rdy());
    end
    idle(12, 1'b1);
    check("drain_empty", 64'(rx_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
